// File: rtl/arb_merge_n.sv
// N-input round-robin arbitrating merge with a registered, source-tagged output stage.
// Define ARBM_BURST_EN to let a winner keep the grant for up to MAX_BURST back-to-back beats.
module arb_merge_n #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNTW      = 16,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IDXW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDXW-1:0]    out_src,
  input  logic               out_ready,
  output logic [CNTW-1:0]    xfer_cnt
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [IDXW-1:0]   r_out_src;
  logic [CNTW-1:0]   r_xfer_cnt;
  logic [IDXW-1:0]   r_rr_ptr;

  logic              w_any;
  logic [IDXW-1:0]   w_win;
  logic [IDXW-1:0]   w_cand;
  logic [N-1:0]      w_onehot;
  logic              w_free;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [IDXW-1:0]   w_win_inc;
  logic [IDXW-1:0]   w_rr_nxt;

  // Search starts at the pointer and wraps; the first valid channel wins.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_cand   = '0;
    w_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IDXW'((32'(r_rr_ptr) + k) % N);
      if (!w_any && in_valid[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
    w_onehot[w_win] = 1'b1;
  end

  assign w_free     = ~r_out_valid | out_ready;
  assign w_in_xfer  = w_any & w_free & ~reset;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_win_inc  = (32'(w_win) == N - 1) ? '0 : w_win + 1'b1;
  assign in_ready   = w_in_xfer ? w_onehot : '0;

`ifdef ARBM_BURST_EN
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  logic [BCW-1:0] r_burst_cnt;
  logic [BCW-1:0] w_burst_inc;
  logic [BCW-1:0] w_burst_nxt;

  // The pointer parks on the burst owner so the search naturally re-grants it;
  // a winner other than the pointer means the grant moved and a new burst starts.
  always_comb begin
    w_burst_inc = (w_win == r_rr_ptr) ? r_burst_cnt + 1'b1 : BCW'(1);
    w_burst_nxt = r_burst_cnt;
    w_rr_nxt    = r_rr_ptr;
    if (w_in_xfer) begin
      if (32'(w_burst_inc) >= MAX_BURST) begin
        w_rr_nxt    = w_win_inc;
        w_burst_nxt = '0;
      end else begin
        w_rr_nxt    = w_win;
        w_burst_nxt = w_burst_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else begin
      r_burst_cnt <= w_burst_nxt;
    end
  end
`else
  always_comb begin
    w_rr_nxt = r_rr_ptr;
    if (w_in_xfer) begin
      w_rr_nxt = w_win_inc;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_xfer_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[32'(w_win)*WIDTH +: WIDTH];
        r_out_src   <= w_win;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_out_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
